// File: rtl/irq_pending_latch_8.sv
// irq_pending_latch_8
//
// Eight-channel interrupt request collector feeding an 8:3 priority encoder.
// Each asynchronous request line is synchronized, then captured into a
// per-channel pending bit either as a level or as a rising edge. The consumer
// retires one channel per cycle through clr_valid/clr_idx. A sticky overrun
// flag records edge events that arrived while the channel was already pending.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      synchronous active-low reset
//   req_in     [7:0] asynchronous request lines
//   edge_mode  [7:0] 1 = rising-edge capture, 0 = level capture
//   mask       [7:0] 1 = channel visible on pend_out
//   clr_valid  single-cycle clear strobe
//   clr_idx    [2:0] channel retired when clr_valid is high
//   pend_out   [7:0] pend & mask, to the encoder input
//   pend_raw   [7:0] unmasked pending register
//   any_pend   |pend_out
//   overrun    [7:0] sticky lost-edge flags

module irq_pending_latch_8 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic [7:0] edge_mode,
  input  logic [7:0] mask,
  input  logic       clr_valid,
  input  logic [2:0] clr_idx,
  output logic [7:0] pend_out,
  output logic [7:0] pend_raw,
  output logic       any_pend,
  output logic [7:0] overrun
);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] req_s;
  logic [7:0] prev_s;
  logic [7:0] pend;
  logic [7:0] ovr;

  logic [7:0] set_evt;
  logic [7:0] clr_hit;
  logic [7:0] pend_next;
  logic [7:0] ovr_next;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    set_evt   = '0;
    clr_hit   = '0;
    pend_next = pend;
    ovr_next  = ovr;
    for (int i = 0; i < 8; i++) begin
      set_evt[i] = edge_mode[i] ? (req_s[i] & ~prev_s[i]) : req_s[i];
      clr_hit[i] = clr_valid && (clr_idx == 3'(i));
      // Set dominates clear, so a level that is still asserted re-pends.
      pend_next[i] = set_evt[i] | (pend[i] & ~clr_hit[i]);
      // A clear in the same cycle as a new edge consumes the old event
      // rather than losing it, so it does not count as an overrun.
      if (edge_mode[i] && set_evt[i] && pend[i] && !clr_hit[i])
        ovr_next[i] = 1'b1;
      else if (clr_hit[i])
        ovr_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_s <= '0;
      pend   <= '0;
      ovr    <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      prev_s <= req_s;
      pend   <= pend_next;
      ovr    <= ovr_next;
    end
  end

  // Mask is applied after the register so unmasking shows up immediately.
  assign pend_out = pend & mask;
  assign pend_raw = pend;
  assign any_pend = |pend_out;
  assign overrun  = ovr;

endmodule

// File: tb/tb_irq_pending_latch_8.sv
module tb_irq_pending_latch_8;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] edge_mode;
  logic [7:0] mask;
  logic       clr_valid;
  logic [2:0] clr_idx;
  logic [7:0] pend_out;
  logic [7:0] pend_raw;
  logic       any_pend;
  logic [7:0] overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: history of req_in values seen at past clock edges,
  // the pending set and the overrun set.
  logic [7:0] hist [0:3];
  logic [7:0] m_pend;
  logic [7:0] m_ovr;

  irq_pending_latch_8 #(.SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .clr_valid (clr_valid),
    .clr_idx   (clr_idx),
    .pend_out  (pend_out),
    .pend_raw  (pend_raw),
    .any_pend  (any_pend),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] enc8(input logic [7:0] v);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] rs, ps, st;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hist[k] = 8'h00;
      m_pend = 8'h00;
      m_ovr  = 8'h00;
    end else begin
      rs = hist[SS-1];
      ps = hist[SS];
      for (int i = 0; i < 8; i++) begin
        logic hit;
        st[i] = edge_mode[i] ? (rs[i] && !ps[i]) : rs[i];
        hit = clr_valid && (int'(clr_idx) == i);
        if (edge_mode[i] && st[i] && m_pend[i] && !hit) m_ovr[i] = 1'b1;
        else if (hit) m_ovr[i] = 1'b0;
        if (st[i]) m_pend[i] = 1'b1;
        else if (hit) m_pend[i] = 1'b0;
      end
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = req_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pend_raw"}, pend_raw, m_pend);
    check({tag, ".pend_out"}, pend_out, m_pend & mask);
    check({tag, ".any_pend"}, {7'd0, any_pend}, {7'd0, |(m_pend & mask)});
    check({tag, ".overrun"},  overrun,  m_ovr);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      tick();
      check_all(tag);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) hist[k] = 8'h00;
    m_pend    = 8'h00;
    m_ovr     = 8'h00;
    rst_n     = 1'b0;
    req_in    = 8'hFF;
    edge_mode = 8'hFF;
    mask      = 8'hFF;
    clr_valid = 1'b0;
    clr_idx   = 3'd0;

    // Reset with all requests high
    tick(); tick();
    check("rst.pend_raw", pend_raw, 8'h00);
    check("rst.pend_out", pend_out, 8'h00);
    check("rst.any_pend", {7'd0, any_pend}, 8'h00);
    check("rst.overrun",  overrun,  8'h00);
    rst_n  = 1'b1;
    req_in = 8'h00;
    ticks(3, "idle");

    // Edge latency: visible after the third edge
    req_in = 8'h08;
    tick(); check("lat1", pend_raw, 8'h00);
    tick(); check("lat2", pend_raw, 8'h00);
    tick(); check("lat3", pend_raw, 8'h08);
    check("lat.pend_out", pend_out, 8'h08);
    check("lat.any_pend", {7'd0, any_pend}, 8'h01);
    check("lat.enc", {4'd0, enc8(pend_out)}, 8'h03);
    check_all("lat");

    // Second edge on ch3 while pending -> overrun
    req_in = 8'h00; ticks(1, "ovr_lo");
    req_in = 8'h08; ticks(3, "ovr_hi");
    check("ovr.set", overrun, 8'h08);
    clr_valid = 1'b1; clr_idx = 3'd3;
    tick(); clr_valid = 1'b0;
    check("clr.pend_raw", pend_raw, 8'h00);
    check("clr.overrun",  overrun,  8'h00);
    check_all("clr");

    // Mask and priority
    req_in = 8'h00; ticks(3, "msk_lo");
    mask = 8'h7F;
    req_in = 8'hC8; ticks(3, "msk_hi");
    check("msk.pend_raw", pend_raw, 8'hC8);
    check("msk.pend_out", pend_out, 8'h48);
    check("msk.enc6", {4'd0, enc8(pend_out)}, 8'h06);
    mask = 8'hFF; #1;
    check("unmsk.pend_out", pend_out, 8'hC8);
    check("unmsk.enc7", {4'd0, enc8(pend_out)}, 8'h07);
    check_all("unmsk");

    // Level mode: cannot clear while line high, clears after it drops
    edge_mode = 8'h00;
    req_in = 8'h01; ticks(3, "lvl_hi");
    clr_valid = 1'b1; clr_idx = 3'd0;
    tick(); clr_valid = 1'b0;
    check("lvl.hold", {7'd0, pend_raw[0]}, 8'h01);
    check_all("lvl.hold");
    req_in = 8'h00; ticks(3, "lvl_lo");
    check("lvl.latched", {7'd0, pend_raw[0]}, 8'h01);
    clr_valid = 1'b1; clr_idx = 3'd0;
    tick(); clr_valid = 1'b0;
    check("lvl.clr", {7'd0, pend_raw[0]}, 8'h00);
    check_all("lvl.clr");

    // Simultaneous set and clear on ch5
    edge_mode = 8'hFF;
    req_in = 8'h20; ticks(3, "sim_a");
    req_in = 8'h00; ticks(3, "sim_b");
    req_in = 8'h20; ticks(2, "sim_c");
    clr_valid = 1'b1; clr_idx = 3'd5;
    tick(); clr_valid = 1'b0;
    check("sim.pend5", {7'd0, pend_raw[5]}, 8'h01);
    check("sim.ovr5",  {7'd0, overrun[5]},  8'h00);
    check_all("sim");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_in    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) edge_mode = 8'($urandom);
      mask      = 8'($urandom);
      clr_valid = ($urandom_range(0, 2) == 0);
      clr_idx   = 3'($urandom);
      ticks(1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch_8.md
Name: irq_pending_latch_8

Overview:
- 8-channel request collector that sits directly upstream of the 8:3 priority encoder.
- Synchronizes 8 asynchronous request lines and captures each as a level or a rising edge into a per-channel pending register.
- Applies a per-channel enable mask and drives the masked pending vector into the encoder's 8-bit `in`.
- The consumer reads the encoder's out/valid and returns the serviced index on a clear strobe, which retires that pending bit.

Parameters:
- SYNC_STAGES, 2, depth of the input synchronizer chain on req_in; legal values 2..3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_in  input  8  asynchronous request lines, one per channel.
- edge_mode  input  8  per channel: 1 = capture rising edge, 0 = capture level.
- mask  input  8  per channel: 1 = enabled to the output, 0 = hidden.
- clr_valid  input  1  single-cycle clear strobe from the consumer.
- clr_idx  input  3  channel index retired when clr_valid=1.
- pend_out  output  8  pend & mask; connects to the encoder `in`.
- pend_raw  output  8  unmasked pending register.
- any_pend  output  1  |pend_out.
- overrun  output  8  sticky per-channel flag: an edge event was lost.

Behaviour:
- Reset:
  - Synchronous: on a rising clk edge with rst_n=0, clear all synchronizer flops, the previous-sample register, pend and overrun.
  - After reset, pend_out=0, pend_raw=0, any_pend=0, overrun=0.
  - rst_n=0 mid-operation discards all pending and overrun state in that cycle; clr_valid is ignored during reset.
- Synchronizer:
  - req_s is req_in passed through a SYNC_STAGES flop chain.
  - prev_s is req_s delayed one further cycle.
  - Both reset to 0, so a line already high at reset release produces one edge event.
- Set event, per channel i:
  - set[i] = edge_mode[i] ? (req_s[i] & ~prev_s[i]) : req_s[i].
- Clear hit, per channel i:
  - clr_hit[i] = clr_valid & (clr_idx == i).
- Pending update, registered:
  - pend[i] <= set[i] | (pend[i] & ~clr_hit[i]).
  - Set wins over clear in the same cycle.
  - Consequence for level mode: a channel whose synchronized level is still high cannot be cleared.
  - A level-mode channel holds after its line drops until it is explicitly cleared.
- Overrun, registered:
  - Set when edge_mode[i]=1, set[i]=1, pend[i]=1 and clr_hit[i]=0.
  - Cleared when clr_hit[i]=1 and the set condition is not true in that cycle.
  - Never set in level mode.
- Clear targeting a channel that is not pending: pend is unchanged; overrun[i] is still cleared.
- Mask:
  - Output-only: masked channels still capture pending and overrun.
  - Unmasking a pending channel makes pend_out reflect it combinationally in the same cycle.
- Outputs:
  - pend_out and any_pend are combinational from the pend register and the mask input.
  - pend_raw and overrun are direct register outputs.
- Latency:
  - A req_in change meeting setup before clk edge 1 appears in pend at edge SYNC_STAGES+1, i.e. edge 3 at the default.
  - A clear applies on the edge where clr_valid is sampled; pend drops the following cycle.
- edge_mode changes take effect in the same cycle in the set computation; existing pend bits are untouched.
- Multiple channels may set in one cycle; each is independent.
- Only one channel can be cleared per cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req_in=8'hFF -> pend_raw=0, pend_out=0, any_pend=0, overrun=0 at release.
- Edge latency: edge_mode=8'hFF, mask=8'hFF, req_in 8'h00->8'h08 before edge 1 -> pend_raw=8'h08 after edge 3, pend_out=8'h08, any_pend=1; the encoder then shows out=3, valid=1.
- Clear and overrun:
  - With pend=8'h08, pulse req_in[3] low then high again -> overrun=8'h08.
  - Then clr_valid=1, clr_idx=3 -> pend_raw=0 and overrun=0 the next cycle.
- Mask and priority:
  - Edge mode, req_in=8'hC8 rising, mask=8'h7F -> pend_raw=8'hC8, pend_out=8'h48; the encoder shows out=6.
  - Set mask=8'hFF -> pend_out=8'hC8 in the same cycle; the encoder shows out=7.
- Level mode: edge_mode=0, req_in[0] held high, clr_idx=0 pulsed -> pend_raw[0] stays 1. Drop req_in[0], wait 3 cycles, clear again -> pend_raw[0]=0.
- Simultaneous set/clear: time a new edge on channel 5 to arrive in the same cycle as clr_valid=1, clr_idx=5 with pend[5]=1 -> pend[5] stays 1 and overrun[5]=0.
